// File: rtl/pix_fx_pkg.sv
// Shared effect encoding, default sizes and the auto-cycle step order
// for the pixel-effect scheduler.
package pix_fx_pkg;

  localparam int unsigned PIX_W_DEF       = 12;
  localparam int unsigned AUTO_FRAMES_DEF = 60;
  localparam int unsigned CNT_W           = 8;

  typedef enum logic [1:0] {
    FX_RAW  = 2'd0,
    FX_GRAY = 2'd1,
    FX_INV  = 2'd2
  } fx_e;

  function automatic fx_e fx_advance(input fx_e m);
    case (m)
      FX_RAW:  return FX_GRAY;
      FX_GRAY: return FX_INV;
      default: return FX_RAW;
    endcase
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer; with EDGE set it also emits a registered
// one-cycle pulse on each synchronized rising edge.
module sync_edge #(
  parameter bit EDGE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  generate
    if (EDGE) begin : g_edge
      logic r_prev;
      logic r_pulse;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_prev  <= 1'b0;
          r_pulse <= 1'b0;
        end else begin
          r_prev  <= r_s2;
          r_pulse <= r_s2 & ~r_prev;
        end
      end

      assign o_q = r_pulse;
    end else begin : g_level
      assign o_q = r_s2;
    end
  endgenerate

endmodule

// File: rtl/pix_effect_sched.sv
// Frame-synchronous effect scheduler: latches user/auto effect changes and
// applies them only at the vsync leading edge, then muxes the pixel stream.
module pix_effect_sched
  import pix_fx_pkg::*;
#(
  parameter int unsigned PIX_W         = PIX_W_DEF,
  parameter int unsigned AUTO_FRAMES   = AUTO_FRAMES_DEF,
  parameter bit          VSYNC_ACT_LOW = 1'b1
) (
  input  logic             clk25,
  input  logic             rst,
  input  logic             gray_req,
  input  logic             inv_req,
  input  logic             auto_en,
  input  logic             vga_vsync,
  input  logic [PIX_W-1:0] raw_pix,
  input  logic [PIX_W-1:0] gray_pix,
  input  logic [PIX_W-1:0] inv_pix,
  output logic [PIX_W-1:0] pix_out,
  output logic [1:0]       mode,
  output logic             mode_pending,
  output logic             frame_tick
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AUTO_FRAMES - 1);

  logic             w_gray_rise;
  logic             w_inv_rise;
  logic             w_auto;
  logic             w_vs_act;
  logic             r_vs_d;
  logic             r_tick;
  fx_e              r_mode;
  fx_e              w_mode_nx;
  fx_e              r_tgt;
  fx_e              w_tgt_nx;
  logic             r_pend;
  logic             w_pend_nx;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nx;
  logic [PIX_W-1:0] r_pix;
  logic [PIX_W-1:0] w_pix;

  sync_edge #(.EDGE(1'b1)) u_gray_sync (
    .clk (clk25), .rst (rst), .i_d (gray_req), .o_q (w_gray_rise)
  );
  sync_edge #(.EDGE(1'b1)) u_inv_sync (
    .clk (clk25), .rst (rst), .i_d (inv_req), .o_q (w_inv_rise)
  );
  sync_edge #(.EDGE(1'b0)) u_auto_sync (
    .clk (clk25), .rst (rst), .i_d (auto_en), .o_q (w_auto)
  );

  assign w_vs_act = VSYNC_ACT_LOW ? ~vga_vsync : vga_vsync;

  // Frame boundary pulse on the active-going vsync edge.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      r_vs_d <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_vs_d <= w_vs_act;
      r_tick <= w_vs_act & ~r_vs_d;
    end
  end

  always_comb begin
    w_mode_nx = r_mode;
    w_tgt_nx  = r_tgt;
    w_pend_nx = r_pend;
    w_cnt_nx  = r_cnt;
    w_pix     = raw_pix;

    if (!w_auto) w_cnt_nx = '0;

    if (r_tick) begin
      if (r_pend) begin
        w_mode_nx = r_tgt;
        w_pend_nx = 1'b0;
        w_cnt_nx  = '0;
      end else if (w_auto) begin
        if (r_cnt >= CNT_LAST) begin
          w_cnt_nx  = '0;
          w_mode_nx = fx_advance(r_mode);
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
    end

    // A request toggles against the effect active after this boundary.
    if (w_inv_rise) begin
      w_tgt_nx  = (w_mode_nx == FX_INV) ? FX_RAW : FX_INV;
      w_pend_nx = 1'b1;
    end else if (w_gray_rise) begin
      w_tgt_nx  = (w_mode_nx == FX_GRAY) ? FX_RAW : FX_GRAY;
      w_pend_nx = 1'b1;
    end

    case (r_mode)
      FX_GRAY: w_pix = gray_pix;
      FX_INV:  w_pix = inv_pix;
      default: w_pix = raw_pix;
    endcase
  end

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      r_mode <= FX_RAW;
      r_tgt  <= FX_RAW;
      r_pend <= 1'b0;
      r_cnt  <= '0;
      r_pix  <= '0;
    end else begin
      r_mode <= w_mode_nx;
      r_tgt  <= w_tgt_nx;
      r_pend <= w_pend_nx;
      r_cnt  <= w_cnt_nx;
      r_pix  <= w_pix;
    end
  end

  assign pix_out      = r_pix;
  assign mode         = r_mode;
  assign mode_pending = r_pend;
  assign frame_tick   = r_tick;

endmodule

// File: doc/pix_effect_sched.md
Name: pix_effect_sched

Overview:
- Frame-synchronous scheduler for the pixel-effect datapath between the frame-buffer read port and vga_ctrl, in the clk25 domain.
- Accepts user effect requests (gray, invert) and an optional auto-cycle mode.
- Changes the active effect only at the leading edge of VGA vsync, so a frame is never rendered with mixed effects.
- Drives the registered pixel mux that feeds vga_ctrl.pix_data.

Parameters:
- PIX_W, 12, pixel width (4:4:4 RGB).
- AUTO_FRAMES, 60, frames per effect step in auto-cycle mode; legal range 1..255.
- VSYNC_ACT_LOW, 1, 1 = vga_vsync pulse is active-low.

Ports:
- clk25  in  1  pixel clock, 25 MHz.
- rst  in  1  asynchronous, active-high reset.
- gray_req  in  1  raw switch/button level, asynchronous to clk25.
- inv_req  in  1  raw switch/button level, asynchronous to clk25.
- auto_en  in  1  raw level, asynchronous to clk25; 1 = auto-cycle effects.
- vga_vsync  in  1  vsync from vga_ctrl, synchronous to clk25.
- raw_pix  in  PIX_W  unprocessed pixel, aligned with gray_pix and inv_pix.
- gray_pix  in  PIX_W  grayscale pixel.
- inv_pix  in  PIX_W  inverted pixel.
- pix_out  out  PIX_W  selected pixel to vga_ctrl.
- mode  out  2  active effect: 0 = RAW, 1 = GRAY, 2 = INV (3 is never driven).
- mode_pending  out  1  a requested change is waiting for a frame boundary.
- frame_tick  out  1  one-cycle pulse at each vsync leading edge.

Behaviour:
- Reset (async on rst high): mode = RAW, pending target = RAW, mode_pending = 0, pix_out = 0, frame_tick = 0, auto frame counter = 0, all synchronizer and edge flops = 0.
- Input synchronization: gray_req, inv_req and auto_en each pass through a 2-FF synchronizer. Rising-edge detect is applied to gray_req and inv_req only. Request-edge latency is 3 cycles from the raw transition.
- Frame boundary: frame_tick = 1 for one cycle on the active-going edge of vga_vsync (falling edge when VSYNC_ACT_LOW = 1). It is registered: 1 cycle after the sampled edge.
- Manual request handling (toggle semantics):
  - gray edge: target = (mode == GRAY) ? RAW : GRAY; mode_pending = 1.
  - inv edge: target = (mode == INV) ? RAW : INV; mode_pending = 1.
  - gray and inv edges in the same cycle: inv wins.
  - A newer request overwrites an older pending target (last request wins).
  - A request whose target equals the current mode still sets mode_pending. It commits as a no-op and clears at the next frame_tick.
- Commit: in the cycle frame_tick = 1, if mode_pending: mode <= target, mode_pending <= 0, auto counter <= 0.
  - If a request edge arrives in the same cycle as frame_tick, the already-pending target commits first; the new request becomes pending for the next frame.
- Auto-cycle: while synchronized auto_en = 1 and mode_pending = 0, the counter increments on each frame_tick.
  - When the count reaches AUTO_FRAMES - 1 and a frame_tick occurs: counter <= 0 and mode advances RAW -> GRAY -> INV -> RAW.
  - Manual requests take precedence: a pending request blocks auto-advance for that boundary.
  - auto_en falling: counter <= 0 immediately; mode is held.
- Pixel mux: pix_out <= raw_pix, gray_pix or inv_pix according to mode. One-cycle registered latency.
  - Because mode only changes in the frame_tick cycle, which is inside vertical blanking, no visible pixel sees a switch.
- Reset mid-frame forces RAW at once; the next frame is rendered RAW.

Decomposition:
- Shared package pix_fx_pkg holds:
  - effect enum: FX_RAW = 2'd0, FX_GRAY = 2'd1, FX_INV = 2'd2;
  - the AUTO_FRAMES default;
  - the PIX_W default.
- One natural sub-module: sync_edge. It is a 2-FF synchronizer plus registered rising-edge pulse, with async active-high reset, instantiated once per request input; auto_en uses the synchronizer only.

Test Plan:
- Reset then idle: after rst, with raw_pix = 12'hABC, gray_pix = 12'h777 and inv_pix = 12'h543, pix_out = 12'hABC on the cycle after, and mode = 0 for 3 frames.
- gray_req pulse mid-frame: mode_pending = 1 within 4 cycles; mode stays 0 until the next vsync leading edge, then mode = 1 and pix_out = 12'h777; a second gray_req returns mode to 0 at the following frame.
- gray_req and inv_req rising in the same cycle: at the next boundary mode = 2 and pix_out = 12'h543.
- Request edge coincident with frame_tick while mode_pending = 1 with target GRAY: GRAY commits at this boundary; the new INV request commits one frame later.
- Auto-cycle with AUTO_FRAMES = 2: with auto_en = 1, mode sequences 0, 0, 1, 1, 2, 2, 0 across successive frames; deasserting auto_en holds mode.
- rst asserted mid-frame while mode = 2 and mode_pending = 1: mode = 0, mode_pending = 0 and pix_out = 0 immediately, without waiting for a clock edge.
